// File: rtl/odd_cnt_checker_if.sv
// rtl/odd_cnt_checker_if.sv - sample stream and status bundle for the odd counter checker
interface odd_cnt_checker_if #(
    parameter int WIDTH = 8
);
    logic             clear_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             locked_o;
    logic             mismatch_o;
    logic             fault_o;
    logic [7:0]       err_cnt_o;
    logic [WIDTH-1:0] expected_o;

    modport master (
        output clear_i, valid_i, data_i,
        input  locked_o, mismatch_o, fault_o, err_cnt_o, expected_o
    );

    modport slave (
        input  clear_i, valid_i, data_i,
        output locked_o, mismatch_o, fault_o, err_cnt_o, expected_o
    );
endinterface

// File: rtl/odd_cnt_checker.sv
// rtl/odd_cnt_checker.sv - locks onto an odd counter stream, flags mismatches, latches fault
module odd_cnt_checker #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 2,
    parameter int LOCK_LEN  = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    odd_cnt_checker_if.slave       bus
);
    localparam int AW = $clog2(LOCK_LEN + 1);
    localparam int CW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_acq_cnt;
    logic [CW-1:0]    r_consec;
    logic [WIDTH-1:0] r_expected;
    logic [7:0]       r_err_cnt;
    logic             r_mismatch;
    logic             r_locked;
    logic             r_fault;

    logic             w_odd;
    logic             w_bad;
    logic [WIDTH-1:0] w_anchor;
    logic [WIDTH-1:0] w_flywheel;

    assign w_odd      = bus.data_i[0];
    assign w_anchor   = bus.data_i + WIDTH'(STEP);
    assign w_flywheel = r_expected + WIDTH'(STEP);
    // In IDLE there is no reference yet, so only parity decides.
    assign w_bad      = !w_odd ||
                        (((r_state == S_ACQUIRE) || (r_state == S_LOCKED)) &&
                         (bus.data_i != r_expected));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_acq_cnt  <= '0;
            r_consec   <= '0;
            r_expected <= '0;
            r_err_cnt  <= '0;
            r_mismatch <= 1'b0;
            r_locked   <= 1'b0;
            r_fault    <= 1'b0;
        end else if (bus.clear_i) begin
            r_state    <= S_IDLE;
            r_acq_cnt  <= '0;
            r_consec   <= '0;
            r_expected <= '0;
            r_err_cnt  <= '0;
            r_mismatch <= 1'b0;
            r_locked   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            if (bus.valid_i) begin
                if (w_bad && (r_state != S_FAULT)) begin
                    r_mismatch <= 1'b1;
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_odd) begin
                            r_expected <= w_anchor;
                            r_acq_cnt  <= AW'(1);
                            r_state    <= S_ACQUIRE;
                        end
                    end
                    S_ACQUIRE: begin
                        if (!w_bad) begin
                            r_expected <= w_flywheel;
                            r_acq_cnt  <= r_acq_cnt + AW'(1);
                            if (r_acq_cnt == AW'(LOCK_LEN - 1)) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                                r_consec <= '0;
                            end
                        end else if (w_odd) begin
                            r_expected <= w_anchor;
                            r_acq_cnt  <= AW'(1);
                        end else begin
                            r_acq_cnt <= '0;
                            r_state   <= S_IDLE;
                        end
                    end
                    S_LOCKED: begin
                        // Flywheel: never re-anchor on a bad value once locked.
                        r_expected <= w_flywheel;
                        if (!w_bad) begin
                            r_consec <= '0;
                        end else if (r_consec == CW'(ERR_LIMIT - 1)) begin
                            r_state  <= S_FAULT;
                            r_locked <= 1'b0;
                            r_fault  <= 1'b1;
                        end else begin
                            r_consec <= r_consec + CW'(1);
                        end
                    end
                    S_FAULT: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.locked_o   = r_locked;
    assign bus.mismatch_o = r_mismatch;
    assign bus.fault_o    = r_fault;
    assign bus.err_cnt_o  = r_err_cnt;
    assign bus.expected_o = r_expected;
endmodule

// File: tb/tb_odd_cnt_checker.sv
// tb/tb_odd_cnt_checker.sv - directed scoreboard bench for odd_cnt_checker
module tb_odd_cnt_checker;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [18:0] exp_q[$];
    string       tag_q[$];

    odd_cnt_checker_if #(.WIDTH(8)) bus ();

    odd_cnt_checker #(
        .WIDTH(8), .STEP(2), .LOCK_LEN(4), .ERR_LIMIT(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] pk(input logic l, input logic m, input logic f,
                                       input logic [7:0] e, input logic [7:0] x);
        return {l, m, f, e, x};
    endfunction

    task automatic expect_out(input logic l, input logic m, input logic f,
                              input logic [7:0] e, input logic [7:0] x, input string t);
        exp_q.push_back(pk(l, m, f, e, x));
        tag_q.push_back(t);
    endtask

    // {locked, mismatch, fault, err_cnt, expected}
    task automatic check();
        logic [18:0] obs;
        logic [18:0] e;
        string       t;
        obs = {bus.locked_o, bus.mismatch_o, bus.fault_o, bus.err_cnt_o, bus.expected_o};
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic [7:0] d,
                        input logic l, input logic m, input logic f,
                        input logic [7:0] e, input logic [7:0] x, input string t);
        bus.valid_i = v;
        bus.clear_i = c;
        bus.data_i  = d;
        expect_out(l, m, f, e, x, t);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic lock_1357();
        step(1, 0, 8'h01, 0, 0, 0, 8'd0, 8'h03, "lock_1");
        step(1, 0, 8'h03, 0, 0, 0, 8'd0, 8'h05, "lock_3");
        step(1, 0, 8'h05, 0, 0, 0, 8'd0, 8'h07, "lock_5");
        step(1, 0, 8'h07, 1, 0, 0, 8'd0, 8'h09, "lock_7");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.data_i  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        expect_out(0, 0, 0, 8'd0, 8'h00, "reset_state");
        check();
        reset = 1'b1;

        lock_1357();

        step(1, 0, 8'h20, 1, 1, 0, 8'd1, 8'h0B, "fly_bad");
        step(1, 0, 8'h0B, 1, 0, 0, 8'd1, 8'h0D, "fly_good");
        step(1, 0, 8'h20, 1, 1, 0, 8'd2, 8'h0F, "fly_bad2");
        step(1, 0, 8'h20, 1, 1, 0, 8'd3, 8'h11, "fly_bad3_nofault");
        step(1, 0, 8'h11, 1, 0, 0, 8'd3, 8'h13, "fly_good2");
        step(1, 1, 8'h13, 0, 0, 0, 8'd0, 8'h00, "clear_drops_sample");

        lock_1357();
        step(1, 0, 8'h10, 1, 1, 0, 8'd1, 8'h0B, "fault_e1");
        step(1, 0, 8'h10, 1, 1, 0, 8'd2, 8'h0D, "fault_e2");
        step(1, 0, 8'h10, 0, 1, 1, 8'd3, 8'h0F, "fault_e3");
        step(1, 0, 8'h10, 0, 0, 1, 8'd3, 8'h0F, "fault_ignore_bad");
        step(1, 0, 8'h0F, 0, 0, 1, 8'd3, 8'h0F, "fault_ignore_good");
        step(0, 0, 8'h00, 0, 0, 1, 8'd3, 8'h0F, "fault_idle");
        step(0, 1, 8'h00, 0, 0, 0, 8'd0, 8'h00, "fault_clear");

        step(1, 0, 8'hF9, 0, 0, 0, 8'd0, 8'hFB, "wrap_f9");
        step(1, 0, 8'hFB, 0, 0, 0, 8'd0, 8'hFD, "wrap_fb");
        step(1, 0, 8'hFD, 0, 0, 0, 8'd0, 8'hFF, "wrap_fd");
        step(1, 0, 8'hFF, 1, 0, 0, 8'd0, 8'h01, "wrap_ff");
        step(0, 0, 8'h40, 1, 0, 0, 8'd0, 8'h01, "wrap_gap1");
        step(1, 0, 8'h01, 1, 0, 0, 8'd0, 8'h03, "wrap_01");
        step(0, 0, 8'h22, 1, 0, 0, 8'd0, 8'h03, "wrap_gap2");
        step(1, 0, 8'h03, 1, 0, 0, 8'd0, 8'h05, "wrap_03");
        step(0, 1, 8'h00, 0, 0, 0, 8'd0, 8'h00, "clear2");

        step(1, 0, 8'h01, 0, 0, 0, 8'd0, 8'h03, "acq_1");
        step(1, 0, 8'h03, 0, 0, 0, 8'd0, 8'h05, "acq_3");
        step(1, 0, 8'h09, 0, 1, 0, 8'd1, 8'h0B, "acq_reanchor_9");
        step(1, 0, 8'h0B, 0, 0, 0, 8'd1, 8'h0D, "acq_11");
        step(1, 0, 8'h0D, 0, 0, 0, 8'd1, 8'h0F, "acq_13");
        step(1, 0, 8'h0F, 1, 0, 0, 8'd1, 8'h11, "acq_15_lock");
        step(0, 1, 8'h00, 0, 0, 0, 8'd0, 8'h00, "clear3");

        step(1, 0, 8'h01, 0, 0, 0, 8'd0, 8'h03, "even_acq_1");
        step(1, 0, 8'h04, 0, 1, 0, 8'd1, 8'h03, "even_acq_4");
        step(1, 0, 8'h05, 0, 0, 0, 8'd1, 8'h07, "idle_restart_5");
        step(1, 0, 8'h07, 0, 0, 0, 8'd1, 8'h09, "idle_restart_7");
        step(1, 0, 8'h09, 0, 0, 0, 8'd1, 8'h0B, "idle_restart_9");
        step(1, 0, 8'h0B, 1, 0, 0, 8'd1, 8'h0D, "idle_restart_lock");
        step(0, 1, 8'h00, 0, 0, 0, 8'd0, 8'h00, "clear4");

        for (int i = 0; i < 300; i++) begin
            step(1, 0, 8'(2 * (i % 100)), 0, 1, 0, (i >= 254) ? 8'd255 : 8'(i + 1), 8'h00,
                 $sformatf("sat_%0d", i));
        end

        bus.valid_i = 1'b1;
        bus.data_i  = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        expect_out(0, 0, 0, 8'd0, 8'h00, "async_reset_now");
        check();
        bus.data_i = 8'h01;
        @(posedge clk);
        #1;
        expect_out(0, 0, 0, 8'd0, 8'h00, "reset_held");
        check();
        reset = 1'b1;
        step(1, 0, 8'h01, 0, 0, 0, 8'd0, 8'h03, "post_reset_1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/odd_cnt_checker.md
# odd_cnt_checker

Downstream monitor for the 8-bit odd counter stage. It samples the counter's output stream and checks two things: every sample is odd, and each sample equals the previous one plus STEP, modulo 2^WIDTH. It locks onto the sequence, flags each mismatch, and counts errors with saturation. It latches a sticky fault when consecutive errors reach a limit. The block sits directly on the counter output and gives the test harness and status logic a single health indication.

## Interface
- WIDTH, 8, data width of the checked stream
- STEP, 2, expected increment per valid sample
- LOCK_LEN, 4, consecutive correct samples required to declare lock (≥2)
- ERR_LIMIT, 3, consecutive mismatches in LOCKED that trigger fault (≥1)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- clear_i  in  1  synchronous clear of state, counters and fault
- valid_i  in  1  data_i holds a sample this cycle
- data_i  in  WIDTH  counter value under check
- locked_o  out  1  high while in LOCKED
- mismatch_o  out  1  one-cycle pulse, registered, one cycle after a bad sample
- fault_o  out  1  high while in FAULT
- err_cnt_o  out  8  total mismatches since reset/clear, saturates at 255
- expected_o  out  WIDTH  value the next valid sample must equal

## Operation
- Reset (reset=0) forces all registers to 0: state IDLE, locked_o=0, mismatch_o=0, fault_o=0, err_cnt_o=0, expected_o=0, acquire and consecutive-error counters=0.
- A sample is "good" when both hold:
  - data_i[0]=1.
  - In ACQUIRE/LOCKED only: data_i == expected_o.
- Any other sample is "bad".
- expected arithmetic is WIDTH-bit wrap-around. 0xFF+2 = 0x01, which is correct.
- A bad sample does the following:
  - Pulses mismatch_o.
  - Increments err_cnt_o unless it is already 255.
- FAULT is the exception: no pulse and no count there.
- State transitions apply only on cycles with valid_i=1. With valid_i=0, all state is held and mismatch_o=0.
- IDLE:
  - Odd sample: expected ← data+STEP, acq_cnt ← 1, go to ACQUIRE.
  - Even sample: bad, stay in IDLE.
- ACQUIRE:
  - Good sample: expected += STEP, acq_cnt++. When acq_cnt reaches LOCK_LEN, go to LOCKED.
  - Bad odd sample: re-anchor with expected ← data+STEP and acq_cnt ← 1. Stay in ACQUIRE.
  - Bad even sample: go to IDLE.
- LOCKED:
  - Every valid sample advances expected += STEP. This is flywheel behaviour; expected is never re-anchored to a bad value.
  - Good sample: consec_err ← 0.
  - Bad sample: consec_err++. When consec_err reaches ERR_LIMIT, go to FAULT.
- FAULT:
  - fault_o=1 and locked_o=0.
  - Samples are ignored: expected frozen, err_cnt frozen, no mismatch pulses.
  - Leaves only via clear_i or reset.
- clear_i=1 has priority over any valid sample in the same cycle, and that sample is dropped.
  - Next state is IDLE, with all counters and outputs at their reset values.
- Simultaneous clear_i and reset: reset wins.

## Timing
- All outputs are registered.
- A sample at edge N is reflected at edge N+1 in:
  - mismatch_o
  - err_cnt_o
  - expected_o
  - locked_o
  - fault_o
- mismatch_o is high for exactly one cycle per bad sample. Back-to-back bad samples keep it high continuously.
- Lock latency: locked_o rises one cycle after the LOCK_LEN-th consecutive good sample.
- Fault latency: fault_o rises one cycle after the ERR_LIMIT-th consecutive bad sample in LOCKED. On that same edge locked_o falls and the final mismatch_o pulse occurs.
- Asynchronous reset takes effect immediately, including mid-stream. Deassertion is synchronous to clk at the integration level.

## Test plan
- Lock: 1,3,5,7 on consecutive cycles (defaults) → locked_o=1 one cycle after 7, err_cnt_o=0, expected_o=0x09.
- Wrap and gaps: lock on 0xF9,0xFB,0xFD,0xFF, then 0x01,0x03 with valid_i=0 gaps between samples → no mismatch_o, locked_o held, expected_o=0x05.
- Flywheel: after locking on 1,3,5,7, send 0x20, then 0x0B:
  - 0x20 → mismatch_o pulses once, err_cnt_o=1, locked_o stays 1.
  - 0x0B → accepted as good, consec_err cleared.
- Fault and clear:
  - Locked at expected 0x09, then send 0x10,0x10,0x10 → fault_o=1 after the third, locked_o=0, err_cnt_o=3.
  - Further samples leave err_cnt_o=3.
  - clear_i → IDLE with all outputs 0.
- Acquire re-anchor:
  - Send 1,3,9 → mismatch_o on 9, then acquisition restarts from 9.
  - Then 11,13,15 → locked_o=1.
  - Then an even value during acquire → return to IDLE.
- Saturation and reset:
  - Send 300 even samples in IDLE → err_cnt_o stops at 255.
  - Assert reset mid-stream → all outputs 0 immediately.
